column_drop_engine: RTL and testbench

//  Parametrised Connect-style drop engine: takes an active-low one-hot column select plus a request strobe,

---
 rtl/connect4_pkg.sv | 33 +++
 rtl/column_height_bank.sv | 45 ++++
 rtl/column_drop_engine.sv | 172 +++++++++++++++++
 tb/tb_column_drop_engine.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/connect4_pkg.sv
// Shared FSM state type and sizing helpers
// for the column drop engine.
package connect4_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_COMMIT,
        S_REJECT,
        S_WAIT_REL
    } state_e;

    function automatic int pos_w(input int cols, input int rows);
        return $clog2(cols * rows) + 1;
    endfunction

    function automatic int col_w(input int cols);
        return $clog2(cols);
    endfunction

    function automatic int hgt_w(input int rows);
        return $clog2(rows + 1);
    endfunction

    function automatic int cnt_w(input int cols, input int rows);
        return $clog2(cols * rows + 1);
    endfunction

    function automatic logic [31:0] invalid_pos(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/column_height_bank.sv
// Per-column saturating fill counters (0..ROWS)
// with a single indexed increment and board clear.
module column_height_bank
    import connect4_pkg::*;
#(
    parameter int COLS  = 4,
    parameter int ROWS  = 4,
    parameter int COL_W = col_w(COLS),
    parameter int H_W   = hgt_w(ROWS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      inc,
    input  logic [COL_W-1:0]          idx,
    output logic [COLS-1:0][H_W-1:0]  height,
    output logic [COLS-1:0]           col_full
);

    logic [COLS-1:0][H_W-1:0] height_q, height_d;

    always_comb begin
        height_d = height_q;
        col_full = '0;
        for (int c = 0; c < COLS; c++) begin
            col_full[c] = (height_q[c] == H_W'(ROWS));
            if (clear) begin
                height_d[c] = '0;
            end else if (inc && idx == COL_W'(c) && !col_full[c]) begin
                height_d[c] = height_q[c] + H_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            height_q <= '0;
        end else begin
            height_q <= height_d;
        end
    end

    assign height = height_q;

endmodule

// File: rtl/column_drop_engine.sv
// Connect-style drop engine: decodes a column select, tracks
// fill heights and turn, and reports the landing slot.
module column_drop_engine
    import connect4_pkg::*;
#(
    parameter int COLS  = 4,
    parameter int ROWS  = 4,
    parameter int POS_W = pos_w(COLS, ROWS),
    parameter int COL_W = col_w(COLS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             req,
    input  logic [COLS-1:0]  sel_n,
    output logic             pos_valid,
    output logic [POS_W-1:0] position,
    output logic [COL_W-1:0] col_idx,
    output logic             player,
    output logic             reject,
    output logic             board_full,
    output logic             busy
);

    localparam int H_W   = hgt_w(ROWS);
    localparam int CNT_W = cnt_w(COLS, ROWS);
    localparam int TOTAL = COLS * ROWS;
    localparam logic [POS_W-1:0] INV_POS = POS_W'(invalid_pos(POS_W));

    state_e           state_q, state_d;
    logic [COLS-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0] moves_q, moves_d;
    logic             turn_q, turn_d;
    logic             full_q, full_d;
    logic             pv_q, pv_d;
    logic             rej_q, rej_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             ply_q, ply_d;

    logic [COLS-1:0][H_W-1:0] height;
    logic [COLS-1:0]          col_full;
    logic                     inc;
    logic [COL_W-1:0]         dec_col;
    logic                     one_low;

    column_height_bank #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .COL_W (COL_W),
        .H_W   (H_W)
    ) u_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .inc      (inc),
        .idx      (col_q),
        .height   (height),
        .col_full (col_full)
    );

    always_comb begin
        dec_col = '0;
        for (int c = 0; c < COLS; c++) begin
            if (!sel_q[c]) dec_col = COL_W'(c);
        end
        one_low = $onehot(~sel_q);
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        moves_d = moves_q;
        turn_d  = turn_q;
        full_d  = full_q;
        pos_d   = INV_POS;
        col_d   = col_q;
        ply_d   = ply_q;
        inc     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (enable && req) begin
                    if (full_q) begin
                        state_d = S_REJECT;
                    end else begin
                        sel_d   = sel_n;
                        state_d = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (one_low && !col_full[dec_col]) begin
                    state_d = S_COMMIT;
                    pos_d   = POS_W'(height[dec_col]) * POS_W'(COLS)
                            + POS_W'(dec_col);
                    col_d   = dec_col;
                    ply_d   = turn_q;
                end else begin
                    state_d = S_REJECT;
                end
            end
            S_COMMIT: begin
                inc     = 1'b1;
                moves_d = moves_q + CNT_W'(1);
                turn_d  = ~turn_q;
                full_d  = (moves_d == CNT_W'(TOTAL));
                state_d = S_WAIT_REL;
            end
            S_REJECT: begin
                state_d = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                if (!req && &sel_n) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // clear lands in the same state as reset
        if (clear) begin
            state_d = S_IDLE;
            sel_d   = '1;
            moves_d = '0;
            turn_d  = 1'b0;
            full_d  = 1'b0;
            pos_d   = INV_POS;
            col_d   = '0;
            ply_d   = 1'b0;
            inc     = 1'b0;
        end
        pv_d  = (state_d == S_COMMIT);
        rej_d = (state_d == S_REJECT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= '1;
            moves_q <= '0;
            turn_q  <= 1'b0;
            full_q  <= 1'b0;
            pv_q    <= 1'b0;
            rej_q   <= 1'b0;
            pos_q   <= INV_POS;
            col_q   <= '0;
            ply_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            moves_q <= moves_d;
            turn_q  <= turn_d;
            full_q  <= full_d;
            pv_q    <= pv_d;
            rej_q   <= rej_d;
            pos_q   <= pos_d;
            col_q   <= col_d;
            ply_q   <= ply_d;
        end
    end

    assign pos_valid  = pv_q;
    assign position   = pos_q;
    assign col_idx    = col_q;
    assign player     = ply_q;
    assign reject     = rej_q;
    assign board_full = full_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_column_drop_engine.sv
// Directed bench for column_drop_engine: a 4x4 and a 7x6
// instance checked against a transaction-level board model.
`timescale 1ns/1ps
module tb_column_drop_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       clr0, en0, req0;
    logic [3:0] sel0;
    logic       pv0, pl0, rj0, bf0, by0;
    logic [4:0] pos0;
    logic [1:0] ci0;

    logic       clr1, en1, req1;
    logic [6:0] sel1;
    logic       pv1, pl1, rj1, bf1, by1;
    logic [5:0] pos1;
    logic [2:0] ci1;

    column_drop_engine #(.COLS(4), .ROWS(4)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clr0), .enable(en0),
        .req(req0), .sel_n(sel0), .pos_valid(pv0), .position(pos0),
        .col_idx(ci0), .player(pl0), .reject(rj0),
        .board_full(bf0), .busy(by0)
    );

    column_drop_engine #(.COLS(7), .ROWS(6), .POS_W(6)) dut7 (
        .clk(clk), .rst_n(rst_n), .clear(clr1), .enable(en1),
        .req(req1), .sel_n(sel1), .pos_valid(pv1), .position(pos1),
        .col_idx(ci1), .player(pl1), .reject(rj1),
        .board_full(bf1), .busy(by1)
    );

    int nchk = 0;
    int nerr = 0;

    // board model: pending selects, column heights, move count, turn
    int qsel[2][$];
    int mh[2][8];
    int mmoves[2];
    int mply[2];

    function automatic int ncols(input int k);
        return (k == 0) ? 4 : 7;
    endfunction
    function automatic int nrows(input int k);
        return (k == 0) ? 4 : 6;
    endfunction
    function automatic int invp(input int k);
        return (k == 0) ? 31 : 63;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset(input int k);
        for (int c = 0; c < 8; c++) mh[k][c] = 0;
        mmoves[k] = 0;
        mply[k] = 0;
        qsel[k].delete();
    endtask

    task automatic step(input int k, input int pv, input int rj,
                        input int pos, input int ci, input int pl,
                        input int bf);
        int cols, rows, s, c, lows, ek, ak;
        cols = ncols(k);
        rows = nrows(k);
        chk($sformatf("u%0d_board_full", k), bf,
            (mmoves[k] == cols * rows) ? 1 : 0);
        if (pv == 0) chk($sformatf("u%0d_idle_pos", k), pos, invp(k));
        if (pv != 0 || rj != 0) begin
            chk($sformatf("u%0d_pulse_pending", k),
                (qsel[k].size() > 0) ? 1 : 0, 1);
            if (qsel[k].size() > 0) begin
                s = qsel[k].pop_front();
                lows = 0;
                c = 0;
                for (int i = 0; i < cols; i++) begin
                    if (!s[i]) begin
                        lows++;
                        c = i;
                    end
                end
                if (mmoves[k] == cols * rows || lows != 1 || mh[k][c] >= rows)
                    ek = 2;
                else
                    ek = 1;
                ak = (pv != 0 && rj == 0) ? 1 : ((rj != 0 && pv == 0) ? 2 : 3);
                chk($sformatf("u%0d_outcome", k), ak, ek);
                if (ek == 1 && ak == 1) begin
                    chk($sformatf("u%0d_position", k), pos, mh[k][c] * cols + c);
                    chk($sformatf("u%0d_col_idx", k), ci, c);
                    chk($sformatf("u%0d_player", k), pl, mply[k]);
                    mh[k][c]++;
                    mmoves[k]++;
                    mply[k] ^= 1;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            step(0, int'(pv0), int'(rj0), int'(pos0), int'(ci0), int'(pl0), int'(bf0));
            step(1, int'(pv1), int'(rj1), int'(pos1), int'(ci1), int'(pl1), int'(bf1));
        end
    end

    task automatic setreq(input int k, input logic r, input int s);
        if (k == 0) begin
            req0 = r;
            sel0 = s[3:0];
        end else begin
            req1 = r;
            sel1 = s[6:0];
        end
    endtask

    function automatic logic pulse(input int k);
        return (k == 0) ? (pv0 | rj0) : (pv1 | rj1);
    endfunction

    function automatic logic busy_of(input int k);
        return (k == 0) ? by0 : by1;
    endfunction

    task automatic drop(input int k, input int s, input int hold,
                        output int kind, output int pos, output int pl);
        int n, extra;
        @(negedge clk);
        setreq(k, 1'b1, s);
        qsel[k].push_back(s);
        kind = 0;
        pos = -1;
        pl = -1;
        n = 0;
        while (kind == 0 && n < 10) begin
            @(negedge clk);
            n++;
            if (k == 0) begin
                if (pv0) begin kind = 1; pos = int'(pos0); pl = int'(pl0); end
                else if (rj0) kind = 2;
            end else begin
                if (pv1) begin kind = 1; pos = int'(pos1); pl = int'(pl1); end
                else if (rj1) kind = 2;
            end
        end
        chk("pulse_seen", (kind != 0) ? 1 : 0, 1);
        extra = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (pulse(k)) extra++;
        end
        chk("no_repeat_while_held", extra, 0);
        @(negedge clk);
        chk("busy_until_release", int'(busy_of(k)), 1);
        setreq(k, 1'b0, 127);
        n = 0;
        while (busy_of(k) && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("idle_after_release", int'(busy_of(k)), 0);
    endtask

    task automatic clear_board(input int k);
        @(negedge clk);
        if (k == 0) clr0 = 1'b1; else clr1 = 1'b1;
        setreq(k, 1'b0, 127);
        model_reset(k);
        @(negedge clk);
        if (k == 0) clr0 = 1'b0; else clr1 = 1'b0;
    endtask

    int kd, ps, pl, n;
    int exp_pos[4] = '{0, 4, 8, 12};
    int exp_ply[4] = '{0, 1, 0, 1};

    initial begin
        rst_n = 1'b0;
        clr0 = 1'b0; en0 = 1'b1; req0 = 1'b0; sel0 = 4'hF;
        clr1 = 1'b0; en1 = 1'b1; req1 = 1'b0; sel1 = 7'h7F;
        model_reset(0);
        model_reset(1);
        repeat (3) @(negedge clk);
        chk("rst_pos_valid", int'(pv0), 0);
        chk("rst_reject", int'(rj0), 0);
        chk("rst_position", int'(pos0), 31);
        chk("rst_col_idx", int'(ci0), 0);
        chk("rst_player", int'(pl0), 0);
        chk("rst_board_full", int'(bf0), 0);
        chk("rst_busy", int'(by0), 0);
        chk("rst_position_7x6", int'(pos1), 63);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            drop(0, 14, 0, kd, ps, pl);
            chk("t1_kind", kd, 1);
            chk("t1_pos", ps, exp_pos[i]);
            chk("t1_player", pl, exp_ply[i]);
        end
        drop(0, 14, 0, kd, ps, pl);
        chk("t1_full_col_reject", kd, 2);

        drop(0, 7, 0, kd, ps, pl);
        chk("t2_pos_col3", ps, 3);
        chk("t2_player_col3", pl, 0);
        drop(0, 11, 0, kd, ps, pl);
        chk("t2_pos_col2", ps, 2);
        chk("t2_player_col2", pl, 1);

        drop(0, 12, 0, kd, ps, pl);
        chk("t3_two_low_reject", kd, 2);
        drop(0, 15, 0, kd, ps, pl);
        chk("t3_none_low_reject", kd, 2);
        drop(0, 13, 0, kd, ps, pl);
        chk("t3_next_pos", ps, 1);
        chk("t3_next_player", pl, 0);

        clear_board(0);
        drop(0, 13, 10, kd, ps, pl);
        chk("t4_held_pos", ps, 1);
        chk("t4_held_player", pl, 0);
        drop(0, 13, 0, kd, ps, pl);
        chk("t4_after_release_pos", ps, 5);
        chk("t4_after_release_player", pl, 1);

        clear_board(0);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                drop(0, (~(1 << c)) & 15, 0, kd, ps, pl);
                chk("t5_fill_pos", ps, r * 4 + c);
                chk("t5_fill_player", pl, (r * 4 + c) % 2);
                chk("t5_full_flag", int'(bf0), (r == 3 && c == 3) ? 1 : 0);
            end
        end
        drop(0, 14, 0, kd, ps, pl);
        chk("t5_full_reject", kd, 2);
        clear_board(0);
        chk("t5_full_cleared", int'(bf0), 0);
        drop(0, 14, 0, kd, ps, pl);
        chk("t5_post_clear_pos", ps, 0);
        chk("t5_post_clear_player", pl, 0);

        @(negedge clk);
        setreq(0, 1'b1, 14);
        @(posedge clk);
        #2;
        chk("t6_in_decode_busy", int'(by0), 1);
        rst_n = 1'b0;
        model_reset(0);
        model_reset(1);
        #1;
        chk("t6_rst_pos_valid", int'(pv0), 0);
        chk("t6_rst_position", int'(pos0), 31);
        chk("t6_rst_col_idx", int'(ci0), 0);
        chk("t6_rst_board_full", int'(bf0), 0);
        chk("t6_rst_busy", int'(by0), 0);
        @(negedge clk);
        setreq(0, 1'b0, 15);
        @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        setreq(0, 1'b1, 11);
        qsel[0].push_back(11);
        n = 0;
        while (!pulse(0) && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t6_commit_before_clear", int'(pv0), 1);
        @(negedge clk);
        chk("t6_wait_rel_busy", int'(by0), 1);
        clr0 = 1'b1;
        setreq(0, 1'b0, 15);
        model_reset(0);
        @(negedge clk);
        clr0 = 1'b0;
        chk("t6_clr_busy", int'(by0), 0);
        chk("t6_clr_position", int'(pos0), 31);
        chk("t6_clr_col_idx", int'(ci0), 0);
        chk("t6_clr_player", int'(pl0), 0);
        drop(0, 11, 0, kd, ps, pl);
        chk("t6_post_clear_pos", ps, 2);
        chk("t6_post_clear_player", pl, 0);

        for (int i = 0; i < 6; i++) begin
            drop(1, 63, 0, kd, ps, pl);
            chk("t6_7x6_pos", ps, 6 + 7 * i);
            chk("t6_7x6_player", pl, i % 2);
        end
        drop(1, 63, 0, kd, ps, pl);
        chk("t6_7x6_full_col_reject", kd, 2);
        chk("t6_7x6_invalid", int'(pos1), 63);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
